// File: rtl/chip8_exec_core.sv
// chip8_exec_core: CHIP-8 fetch/execute core with V regs, I, PC, stack
// and timers in flops; display, key and bulk-memory opcodes halt.
module chip8_exec_core #(
  parameter int ADDR_WIDTH = 12,
  parameter int STACK_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET = 'h200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter bit QUIRK_SHIFT_VY = 1'b0,
  parameter bit QUIRK_VF_RESET = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  chip8_clk_in,
  input  logic                  active_in,
  input  logic                  timer_decr_in,
  input  logic                  mem_ready_in,
  input  logic                  mem_valid_in,
  input  logic [7:0]            mem_data_in,
  output logic                  mem_valid_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  instr_done_out,
  output logic                  halted_out,
  output logic [2:0]            error_out,
  output logic                  active_audio_out,
  input  logic [3:0]            dbg_sel_in,
  output logic [7:0]            dbg_reg_out
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = $clog2(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_TWO = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_FOUR = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_HI,
    S_WAIT_HI,
    S_REQ_LO,
    S_WAIT_LO,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                state;
  logic [7:0]            v [16];
  logic [ADDR_WIDTH-1:0] i_reg;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SPW-1:0]        sp;
  logic [7:0]            dt;
  logic [7:0]            st;
  logic [15:0]           lfsr;
  logic [7:0]            op_hi;
  logic [7:0]            op_lo;

  logic [15:0]           op;
  logic [3:0]            x;
  logic [3:0]            y;
  logic [3:0]            n;
  logic [7:0]            kk;
  logic [ADDR_WIDTH-1:0] nnn_a;
  logic [7:0]            vx;
  logic [7:0]            vy;
  logic [8:0]            sum;
  logic [7:0]            sh_src;
  logic [SIW-1:0]        sp_top;

  logic [ADDR_WIDTH-1:0] pc_nx;
  logic                  wr_v;
  logic [7:0]            v_wd;
  logic                  wr_f;
  logic [7:0]            f_wd;
  logic                  wr_i;
  logic [ADDR_WIDTH-1:0] i_wd;
  logic                  wr_dt;
  logic                  wr_st;
  logic                  push;
  logic                  pop;
  logic [2:0]            err;
  logic                  exec_go;

  assign op      = {op_hi, op_lo};
  assign x       = op[11:8];
  assign y       = op[7:4];
  assign n       = op[3:0];
  assign kk      = op[7:0];
  assign nnn_a   = ADDR_WIDTH'(op[11:0]);
  assign vx      = v[x];
  assign vy      = v[y];
  assign sum     = {1'b0, vx} + {1'b0, vy};
  assign sh_src  = QUIRK_SHIFT_VY ? vy : vx;
  assign sp_top  = SIW'(sp - SP_ONE);
  assign exec_go = active_in && (state == S_EXEC);

  always_comb begin
    pc_nx = pc + A_TWO;
    wr_v  = 1'b0;
    v_wd  = 8'h00;
    wr_f  = 1'b0;
    f_wd  = 8'h00;
    wr_i  = 1'b0;
    i_wd  = i_reg;
    wr_dt = 1'b0;
    wr_st = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    err   = 3'd0;
    unique case (op[15:12])
      4'h0: begin
        if (op != 16'h00EE) begin
          err = 3'd1;
        end else if (sp == '0) begin
          err = 3'd5;
        end else begin
          pop   = 1'b1;
          pc_nx = stack[sp_top];
        end
      end
      4'h1: pc_nx = nnn_a;
      4'h2: begin
        if (sp == SP_FULL) begin
          err = 3'd4;
        end else begin
          push  = 1'b1;
          pc_nx = nnn_a;
        end
      end
      4'h3: if (vx == kk) pc_nx = pc + A_FOUR;
      4'h4: if (vx != kk) pc_nx = pc + A_FOUR;
      4'h5: begin
        if (n != 4'h0) err = 3'd1;
        else if (vx == vy) pc_nx = pc + A_FOUR;
      end
      4'h9: begin
        if (n != 4'h0) err = 3'd1;
        else if (vx != vy) pc_nx = pc + A_FOUR;
      end
      4'h6: begin
        wr_v = 1'b1;
        v_wd = kk;
      end
      4'h7: begin
        wr_v = 1'b1;
        v_wd = vx + kk;
      end
      4'h8: begin
        wr_v = 1'b1;
        unique case (n)
          4'h0: v_wd = vy;
          4'h1: begin
            v_wd = vx | vy;
            wr_f = QUIRK_VF_RESET;
          end
          4'h2: begin
            v_wd = vx & vy;
            wr_f = QUIRK_VF_RESET;
          end
          4'h3: begin
            v_wd = vx ^ vy;
            wr_f = QUIRK_VF_RESET;
          end
          4'h4: begin
            v_wd = sum[7:0];
            wr_f = 1'b1;
            f_wd = {7'd0, sum[8]};
          end
          4'h5: begin
            v_wd = vx - vy;
            wr_f = 1'b1;
            f_wd = {7'd0, vx >= vy};
          end
          4'h7: begin
            v_wd = vy - vx;
            wr_f = 1'b1;
            f_wd = {7'd0, vy >= vx};
          end
          4'h6: begin
            v_wd = {1'b0, sh_src[7:1]};
            wr_f = 1'b1;
            f_wd = {7'd0, sh_src[0]};
          end
          4'hE: begin
            v_wd = {sh_src[6:0], 1'b0};
            wr_f = 1'b1;
            f_wd = {7'd0, sh_src[7]};
          end
          default: begin
            wr_v = 1'b0;
            err  = 3'd1;
          end
        endcase
      end
      4'hA: begin
        wr_i = 1'b1;
        i_wd = nnn_a;
      end
      4'hB: pc_nx = nnn_a + ADDR_WIDTH'(v[0]);
      4'hC: begin
        wr_v = 1'b1;
        v_wd = lfsr[7:0] & kk;
      end
      4'hF: begin
        unique case (kk)
          8'h07: begin
            wr_v = 1'b1;
            v_wd = dt;
          end
          8'h15: wr_dt = 1'b1;
          8'h18: wr_st = 1'b1;
          8'h1E: begin
            wr_i = 1'b1;
            i_wd = i_reg + ADDR_WIDTH'(vx);
          end
          default: err = 3'd1;
        endcase
      end
      default: err = 3'd1;
    endcase
  end

  // LFSR free-runs every cycle so RND depends on wall-clock timing
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dt               <= 8'h00;
      st               <= 8'h00;
      active_audio_out <= 1'b0;
    end else begin
      active_audio_out <= (st != 8'h00);
      if (exec_go && err == 3'd0 && wr_dt) dt <= vx;
      else if (timer_decr_in && dt != 8'h00) dt <= dt - 8'h01;
      if (exec_go && err == 3'd0 && wr_st) st <= vx;
      else if (timer_decr_in && st != 8'h00) st <= st - 8'h01;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      pc             <= PC_RESET;
      i_reg          <= '0;
      sp             <= '0;
      op_hi          <= 8'h00;
      op_lo          <= 8'h00;
      mem_valid_out  <= 1'b0;
      mem_addr_out   <= '0;
      instr_done_out <= 1'b0;
      halted_out     <= 1'b0;
      error_out      <= 3'd0;
      for (int k = 0; k < 16; k++) v[k] <= 8'h00;
      for (int k = 0; k < STACK_DEPTH; k++) stack[k] <= '0;
    end else begin
      instr_done_out <= 1'b0;
      if (active_in) begin
        unique case (state)
          S_IDLE: begin
            if (chip8_clk_in) begin
              state         <= S_REQ_HI;
              mem_valid_out <= 1'b1;
              mem_addr_out  <= pc;
            end
          end
          S_REQ_HI: begin
            if (mem_ready_in) begin
              state         <= S_WAIT_HI;
              mem_valid_out <= 1'b0;
            end
          end
          S_WAIT_HI: begin
            if (mem_valid_in) begin
              op_hi         <= mem_data_in;
              state         <= S_REQ_LO;
              mem_valid_out <= 1'b1;
              mem_addr_out  <= pc + A_ONE;
            end
          end
          S_REQ_LO: begin
            if (mem_ready_in) begin
              state         <= S_WAIT_LO;
              mem_valid_out <= 1'b0;
            end
          end
          S_WAIT_LO: begin
            if (mem_valid_in) begin
              op_lo <= mem_data_in;
              state <= S_EXEC;
            end
          end
          S_EXEC: begin
            if (err != 3'd0) begin
              error_out  <= err;
              halted_out <= 1'b1;
              state      <= S_HALT;
            end else begin
              pc             <= pc_nx;
              instr_done_out <= 1'b1;
              state          <= S_IDLE;
              if (wr_v) v[x] <= v_wd;
              if (wr_f) v[15] <= f_wd;
              if (wr_i) i_reg <= i_wd;
              if (push) begin
                stack[SIW'(sp)] <= pc + A_TWO;
                sp              <= sp + SP_ONE;
              end
              if (pop) sp <= sp - SP_ONE;
            end
          end
          S_HALT: state <= S_HALT;
          default: state <= S_HALT;
        endcase
      end
    end
  end

  assign pc_out      = pc;
  assign dbg_reg_out = v[dbg_sel_in];

endmodule

// File: tb/tb_chip8_exec_core.sv
// tb_chip8_exec_core: table vectors, directed corner sequences and
// random opcodes checked against an architectural CHIP-8 model.
module tb_chip8_exec_core;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        chip8_clk_in = 1'b0;
  logic        active_in = 1'b1;
  logic        timer_decr_in = 1'b0;
  logic        mem_ready_in = 1'b1;
  logic        mem_valid_in = 1'b0;
  logic [7:0]  mem_data_in = 8'h00;
  logic        mem_valid_out;
  logic [11:0] mem_addr_out;
  logic [11:0] pc_out;
  logic        instr_done_out;
  logic        halted_out;
  logic [2:0]  error_out;
  logic        active_audio_out;
  logic [3:0]  dbg_sel_in = 4'h0;
  logic [7:0]  dbg_reg_out;

  chip8_exec_core dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .chip8_clk_in(chip8_clk_in),
    .active_in(active_in),
    .timer_decr_in(timer_decr_in),
    .mem_ready_in(mem_ready_in),
    .mem_valid_in(mem_valid_in),
    .mem_data_in(mem_data_in),
    .mem_valid_out(mem_valid_out),
    .mem_addr_out(mem_addr_out),
    .pc_out(pc_out),
    .instr_done_out(instr_done_out),
    .halted_out(halted_out),
    .error_out(error_out),
    .active_audio_out(active_audio_out),
    .dbg_sel_in(dbg_sel_in),
    .dbg_reg_out(dbg_reg_out)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] mem [4096];
  int acc_cnt = 0;

  // arbiter: answers one cycle after each accepted request
  always @(posedge clk_in) begin
    mem_valid_in <= mem_valid_out && mem_ready_in;
    mem_data_in  <= mem[mem_addr_out];
    if (mem_valid_out && mem_ready_in) acc_cnt <= acc_cnt + 1;
  end

  int tests = 0;
  int failed = 0;

  int mv [16];
  int mpc;
  int mstk [$];
  int merr;
  bit mhalt;
  int mdt;

  typedef struct packed {
    logic [3:0] n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [7:0] f;
  } alu_vec_t;

  alu_vec_t tbl [13];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 16; k++) mv[k] = 0;
    mpc = 'h200;
    mstk.delete();
    merr = 0;
    mhalt = 0;
    mdt = 0;
  endtask

  task automatic m_step(input logic [15:0] op);
    int x, y, n, kk, nnn, npc, vx, vy, r, f, e;
    bit wr, wf;
    x = int'(op[11:8]);
    y = int'(op[7:4]);
    n = int'(op[3:0]);
    kk = int'(op[7:0]);
    nnn = int'(op[11:0]);
    vx = mv[x];
    vy = mv[y];
    npc = mpc + 2;
    wr = 0; wf = 0; e = 0; r = 0; f = 0;
    case (op[15:12])
      4'h0: if (op != 16'h00EE) e = 1;
            else if (mstk.size() == 0) e = 5;
            else npc = mstk.pop_back();
      4'h1: npc = nnn;
      4'h2: if (mstk.size() == 16) e = 4;
            else begin mstk.push_back((mpc + 2) % 4096); npc = nnn; end
      4'h3: if (vx == kk) npc = mpc + 4;
      4'h4: if (vx != kk) npc = mpc + 4;
      4'h5: if (n != 0) e = 1; else if (vx == vy) npc = mpc + 4;
      4'h9: if (n != 0) e = 1; else if (vx != vy) npc = mpc + 4;
      4'h6: begin wr = 1; r = kk; end
      4'h7: begin wr = 1; r = (vx + kk) % 256; end
      4'h8: begin
        wr = 1;
        case (n)
          0: r = vy;
          1: r = vx | vy;
          2: r = vx & vy;
          3: r = vx ^ vy;
          4: begin r = (vx + vy) % 256; wf = 1; f = (vx + vy > 255); end
          5: begin r = (vx - vy + 256) % 256; wf = 1; f = (vx >= vy); end
          7: begin r = (vy - vx + 256) % 256; wf = 1; f = (vy >= vx); end
          6: begin r = vx / 2; wf = 1; f = vx % 2; end
          14: begin r = (vx * 2) % 256; wf = 1; f = vx / 128; end
          default: begin wr = 0; e = 1; end
        endcase
      end
      4'hA: ;
      4'hB: npc = nnn + mv[0];
      4'hC: begin wr = 1; r = 0; end
      4'hF: case (kk)
        'h07: begin wr = 1; r = mdt; end
        'h15: mdt = vx;
        'h18, 'h1E: ;
        default: e = 1;
      endcase
      default: e = 1;
    endcase
    if (e != 0) begin
      merr = e;
      mhalt = 1;
    end else begin
      if (wr) mv[x] = r;
      if (wf) mv[15] = f;
      mpc = npc % 4096;
    end
  endtask

  task automatic rdv(input int idx, output int val);
    dbg_sel_in = 4'(idx);
    #1;
    val = int'(dbg_reg_out);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    chip8_clk_in = 1'b0;
    timer_decr_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    m_reset();
  endtask

  task automatic do_op(input logic [15:0] op, output bit done);
    int c;
    mem[mpc] = op[15:8];
    mem[(mpc + 1) % 4096] = op[7:0];
    @(negedge clk_in);
    chip8_clk_in = 1'b1;
    @(negedge clk_in);
    chip8_clk_in = 1'b0;
    c = 0;
    while (!instr_done_out && !halted_out && c < 60) begin
      @(negedge clk_in);
      c++;
    end
    if (c >= 60) begin
      tests++;
      failed++;
      $display("FAIL op_timeout: op %h got no completion", op);
    end
    done = instr_done_out;
    m_step(op);
  endtask

  task automatic op1(input logic [15:0] op);
    bit d;
    do_op(op, d);
  endtask

  task automatic strobe();
    @(negedge clk_in);
    timer_decr_in = 1'b1;
    @(negedge clk_in);
    timer_decr_in = 1'b0;
    if (mdt > 0) mdt--;
  endtask

  task automatic check_all(input string tag);
    int val;
    chk({tag, "_pc"}, int'(pc_out), mpc);
    chk({tag, "_err"}, int'(error_out), merr);
    chk({tag, "_halt"}, int'(halted_out), int'(mhalt));
    for (int k = 0; k < 16; k++) begin
      rdv(k, val);
      chk($sformatf("%s_v%0d", tag, k), val, mv[k]);
    end
  endtask

  initial begin
    int val, pcs, acc0, dn, vs;
    bit d, seen;
    logic [15:0] op;
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    tbl[0]  = '{4'h4, 8'hF0, 8'h20, 8'h10, 8'h01};
    tbl[1]  = '{4'h4, 8'h10, 8'h20, 8'h30, 8'h00};
    tbl[2]  = '{4'h5, 8'h10, 8'h20, 8'hF0, 8'h00};
    tbl[3]  = '{4'h5, 8'h20, 8'h20, 8'h00, 8'h01};
    tbl[4]  = '{4'h7, 8'h10, 8'h20, 8'h10, 8'h01};
    tbl[5]  = '{4'h7, 8'h30, 8'h20, 8'hF0, 8'h00};
    tbl[6]  = '{4'h6, 8'h85, 8'h00, 8'h42, 8'h01};
    tbl[7]  = '{4'hE, 8'h85, 8'h00, 8'h0A, 8'h01};
    tbl[8]  = '{4'hE, 8'h40, 8'h00, 8'h80, 8'h00};
    tbl[9]  = '{4'h1, 8'hF0, 8'h0F, 8'hFF, 8'h5A};
    tbl[10] = '{4'h2, 8'hF0, 8'h3C, 8'h30, 8'h5A};
    tbl[11] = '{4'h3, 8'hFF, 8'h0F, 8'hF0, 8'h5A};
    tbl[12] = '{4'h0, 8'h12, 8'h34, 8'h34, 8'h5A};

    do_reset();
    @(negedge clk_in);
    chk("rst_pc", int'(pc_out), 'h200);
    chk("rst_mvalid", int'(mem_valid_out), 0);
    chk("rst_maddr", int'(mem_addr_out), 0);
    chk("rst_done", int'(instr_done_out), 0);
    chk("rst_halt", int'(halted_out), 0);
    chk("rst_err", int'(error_out), 0);
    chk("rst_audio", int'(active_audio_out), 0);
    check_all("rst");

    // frozen core ignores the tick
    active_in = 1'b0;
    acc0 = acc_cnt;
    chip8_clk_in = 1'b1;
    @(negedge clk_in);
    chip8_clk_in = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("freeze_req", acc_cnt - acc0 + int'(mem_valid_out), 0);
    active_in = 1'b1;

    dn = 0;
    do_op(16'h6A3C, d); dn += int'(d);
    do_op(16'h7A05, d); dn += int'(d);
    rdv(10, val);
    chk("tp1_va", val, 'h41);
    chk("tp1_pc", int'(pc_out), 'h204);
    chk("tp1_pulses", dn, 2);
    chk("tp1_err", int'(error_out), 0);

    foreach (tbl[t]) begin
      op1({8'h61, tbl[t].a});
      op1({8'h62, tbl[t].b});
      op1(16'h6F5A);
      op1({12'h812, tbl[t].n});
      rdv(1, val);
      chk($sformatf("alu%0d_vx", t), val, int'(tbl[t].r));
      rdv(15, val);
      chk($sformatf("alu%0d_vf", t), val, int'(tbl[t].f));
    end
    check_all("alu");

    op1(16'h6FF0); op1(16'h6220); op1(16'h8F24);
    rdv(15, val);
    chk("vf_dest", val, 1);

    pcs = int'(pc_out);
    op1(16'h3A41);
    chk("skip_taken", int'(pc_out), (pcs + 4) % 4096);
    pcs = int'(pc_out);
    op1(16'h3A40);
    chk("skip_not", int'(pc_out), (pcs + 2) % 4096);

    op1(16'h1200);
    op1(16'h2300);
    chk("call_pc", int'(pc_out), 'h300);
    op1(16'h00EE);
    chk("ret_pc", int'(pc_out), 'h202);

    // arbiter stalls in REQ_HI
    mem_ready_in = 1'b0;
    mem[mpc] = 8'h6B;
    mem[mpc + 1] = 8'h77;
    acc0 = acc_cnt;
    @(negedge clk_in);
    chip8_clk_in = 1'b1;
    @(negedge clk_in);
    chip8_clk_in = 1'b0;
    vs = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_valid_out && int'(mem_addr_out) == mpc) vs++;
      @(negedge clk_in);
    end
    chk("stall_hold", vs, 10);
    chk("stall_acc", acc_cnt - acc0, 0);
    mem_ready_in = 1'b1;
    for (int c = 0; c < 20 && !instr_done_out; c++) @(negedge clk_in);
    chk("stall_done", int'(instr_done_out), 1);
    m_step(16'h6B77);
    chk("stall_acc2", acc_cnt - acc0, 2);

    op1(16'h6303); op1(16'hC300);
    rdv(3, val);
    chk("rnd_mask0", val, 0);

    op1(16'h6503); op1(16'hF518);
    repeat (2) @(negedge clk_in);
    chk("audio_on", int'(active_audio_out), 1);
    strobe(); strobe();
    repeat (2) @(negedge clk_in);
    chk("audio_2dec", int'(active_audio_out), 1);
    strobe();
    repeat (2) @(negedge clk_in);
    chk("audio_off", int'(active_audio_out), 0);

    op1(16'h6509); op1(16'hF515);
    op1(16'h6507);
    // DT write lands on the same edge as a decrement strobe
    mem[mpc] = 8'hF5;
    mem[mpc + 1] = 8'h15;
    @(negedge clk_in);
    chip8_clk_in = 1'b1;
    @(negedge clk_in);
    chip8_clk_in = 1'b0;
    repeat (3) @(negedge clk_in);
    @(negedge clk_in);
    timer_decr_in = 1'b1;
    chk("lat_early", int'(instr_done_out), 0);
    @(negedge clk_in);
    timer_decr_in = 1'b0;
    chk("lat_done", int'(instr_done_out), 1);
    m_step(16'hF515);
    op1(16'hF607);
    rdv(6, val);
    chk("dt_write_wins", val, 7);
    check_all("dt");

    op1(16'h00EE);
    chk("uflow_err", int'(error_out), 5);
    chk("uflow_halt", int'(halted_out), 1);

    do_reset();
    for (int k = 0; k < 17; k++) op1(16'h2000 | 16'((mpc + 16) % 4096));
    chk("oflow_err", int'(error_out), 4);
    chk("oflow_halt", int'(halted_out), 1);
    acc0 = acc_cnt;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      chip8_clk_in = (c % 5 == 0);
      @(negedge clk_in);
      if (mem_valid_out) seen = 1;
    end
    chip8_clk_in = 1'b0;
    chk("oflow_noreq", int'(seen) + acc_cnt - acc0, 0);
    check_all("oflow");

    do_reset();
    op1(16'hD125);
    chk("bad_err", int'(error_out), 1);
    chk("bad_halt", int'(halted_out), 1);
    chk("bad_pc", int'(pc_out), 'h200);

    do_reset();
    mem['h200] = 8'h6A;
    mem['h201] = 8'h3C;
    @(negedge clk_in);
    chip8_clk_in = 1'b1;
    @(negedge clk_in);
    chip8_clk_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_mvalid", int'(mem_valid_out), 0);
    rst_in = 1'b0;
    m_reset();
    repeat (3) @(negedge clk_in);
    chk("midrst_mvalid2", int'(mem_valid_out), 0);
    chk("midrst_done", int'(instr_done_out), 0);
    check_all("midrst");
    do_op(16'h6A3C, d);
    chk("midrst_op", int'(d), 1);
    check_all("midrst2");

    do_reset();
    for (int s = 0; s < 80; s++) begin
      int x, y, kk;
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      kk = $urandom_range(0, 255);
      case ($urandom_range(0, 13))
        0: op = 16'h6000 | 16'(x << 8 | kk);
        1: op = 16'h7000 | 16'(x << 8 | kk);
        2: begin
          int nl [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 14};
          op = 16'h8000 | 16'(x << 8 | y << 4 | nl[$urandom_range(0, 8)]);
        end
        3: op = 16'h3000 | 16'(x << 8 | ($urandom_range(0, 1) ? mv[x] : kk));
        4: op = 16'h4000 | 16'(x << 8 | ($urandom_range(0, 1) ? mv[x] : kk));
        5: op = 16'h5000 | 16'(x << 8 | y << 4);
        6: op = 16'h9000 | 16'(x << 8 | y << 4);
        7: op = 16'hA000 | 16'($urandom_range(0, 4095));
        8: op = 16'hF01E | 16'(x << 8);
        9: op = 16'hF015 | 16'(x << 8);
        10: op = 16'hF007 | 16'(x << 8);
        11: op = ($urandom_range(0, 1) ? 16'hB000 : 16'h1000)
                 | 16'($urandom_range(0, 4095));
        12: op = (mstk.size() < 16) ? 16'h2000 | 16'($urandom_range(0, 4095))
                                    : 16'h6000 | 16'(x << 8 | kk);
        default: op = (mstk.size() > 0) ? 16'h00EE : 16'h6000 | 16'(x << 8 | kk);
      endcase
      op1(op);
      check_all($sformatf("rnd%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
